// File: rtl/costas_pkg.sv
// Shared types for the Costas loop acquisition sequencer: FSM states, NCO gain codes
// and a small saturating-increment helper used by the window and retry counters.
package costas_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        TRACK  = 2'd2,
        LOCKED = 2'd3
    } state_t;

    localparam logic [1:0] GAIN_WIDE   = 2'd2;
    localparam logic [1:0] GAIN_MED    = 2'd1;
    localparam logic [1:0] GAIN_NARROW = 2'd0;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/costas_lock_metric.sv
// Lock metric: accumulates (|I|>>SH) - (|Q|>>SH) over 2**WIN_LOG2 accepted samples and
// flags the window end together with the good/bad verdict in the same cycle as the last sample.
module costas_lock_metric
    import costas_pkg::*;
#(
    parameter int W        = 32,
    parameter int SH       = 8,
    parameter int WIN_LOG2 = 6,
    parameter int LOCK_THR = 4096
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         sample,
    input  logic [W-1:0] lpf_i,
    input  logic [W-1:0] lpf_q,
    output logic         win_done,
    output logic         win_good
);

    localparam int AW = W + WIN_LOG2 + 1;
    localparam logic signed [AW-1:0] THR = AW'(LOCK_THR);

    logic signed [AW-1:0] acc_reg;
    logic [WIN_LOG2-1:0]  cnt_reg;
    logic [W-1:0]         lpf_ch [2];
    logic [W-1:0]         mag [2];
    logic signed [W:0]    metric;
    logic signed [AW-1:0] metric_ext;
    logic signed [AW-1:0] acc_sum;

    // The most negative input has no positive twin; clamp it instead of letting it wrap.
    function automatic logic [W-1:0] sat_abs(input logic signed [W-1:0] x);
        if (x == {1'b1, {(W-1){1'b0}}})
            return {1'b0, {(W-1){1'b1}}};
        else if (x[W-1])
            return $unsigned(-x);
        else
            return $unsigned(x);
    endfunction

    assign lpf_ch[0] = lpf_i;
    assign lpf_ch[1] = lpf_q;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_mag
            assign mag[gi] = sat_abs(lpf_ch[gi]) >> SH;
        end
    endgenerate

    assign metric     = $signed({1'b0, mag[0]}) - $signed({1'b0, mag[1]});
    assign metric_ext = {{WIN_LOG2{metric[W]}}, metric};
    assign acc_sum    = acc_reg + metric_ext;
    assign win_done   = sample && (cnt_reg == '1);
    assign win_good   = (acc_sum >= THR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_reg <= '0;
            cnt_reg <= '0;
        end else if (clr) begin
            acc_reg <= '0;
            cnt_reg <= '0;
        end else if (sample) begin
            if (win_done) begin
                acc_reg <= '0;
                cnt_reg <= '0;
            end else begin
                acc_reg <= acc_sum;
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/costas_acq_ctrl.sv
// Acquisition/tracking sequencer for the Costas BPSK loop: walks IDLE/ACQ/TRACK/LOCKED from
// windowed lock-metric verdicts, drives NCO gain/clear, gates the synchronizer, counts retries.
module costas_acq_ctrl
    import costas_pkg::*;
#(
    parameter int W          = 32,
    parameter int SH         = 8,
    parameter int WIN_LOG2   = 6,
    parameter int LOCK_THR   = 4096,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 2,
    parameter int ACQ_MAX    = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         PushADC,
    input  logic [W-1:0] lpf_i,
    input  logic [W-1:0] lpf_q,
    input  logic         stopIn,
    input  logic         sync_match,
    output logic [1:0]   gain_sel,
    output logic         nco_clr,
    output logic         sync_en,
    output logic         locked,
    output logic         lost,
    output logic [1:0]   state,
    output logic [7:0]   retries
);

    localparam int ACW = $clog2(ACQ_MAX + 1);
    localparam logic [ACW-1:0] ACQ_LAST   = ACW'(ACQ_MAX - 1);
    localparam logic [7:0]     LOCK_CNT8  = 8'(LOCK_CNT);
    localparam logic [7:0]     UNLOCK_CNT8 = 8'(UNLOCK_CNT);

    state_t         state_reg;
    logic [7:0]     good_cnt_reg;
    logic [7:0]     bad_cnt_reg;
    logic [ACW-1:0] acq_win_cnt_reg;
    logic [7:0]     good_next;
    logic [7:0]     bad_next;
    logic           sample;
    logic           win_done;
    logic           win_good;

    assign sample = PushADC && !stopIn && enable && (state_reg != IDLE);
    assign state  = state_reg;

    costas_lock_metric #(
        .W        (W),
        .SH       (SH),
        .WIN_LOG2 (WIN_LOG2),
        .LOCK_THR (LOCK_THR)
    ) u_metric (
        .clk      (clk),
        .reset    (reset),
        .clr      (!enable),
        .sample   (sample),
        .lpf_i    (lpf_i),
        .lpf_q    (lpf_q),
        .win_done (win_done),
        .win_good (win_good)
    );

    always_comb begin
        good_next = good_cnt_reg;
        bad_next  = bad_cnt_reg;
        if (win_done) begin
            if (win_good) begin
                good_next = sat_inc8(good_cnt_reg);
                bad_next  = '0;
            end else begin
                bad_next  = sat_inc8(bad_cnt_reg);
                good_next = '0;
            end
        end
    end

    // Any state change, ACQ timeout or disable restarts the good/bad/ACQ-window bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            gain_sel        <= GAIN_WIDE;
            nco_clr         <= 1'b0;
            sync_en         <= 1'b0;
            locked          <= 1'b0;
            lost            <= 1'b0;
            retries         <= '0;
            good_cnt_reg    <= '0;
            bad_cnt_reg     <= '0;
            acq_win_cnt_reg <= '0;
        end else begin
            nco_clr <= 1'b0;
            lost    <= 1'b0;
            if (!enable) begin
                state_reg       <= IDLE;
                gain_sel        <= GAIN_WIDE;
                sync_en         <= 1'b0;
                locked          <= 1'b0;
                good_cnt_reg    <= '0;
                bad_cnt_reg     <= '0;
                acq_win_cnt_reg <= '0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        state_reg       <= ACQ;
                        gain_sel        <= GAIN_WIDE;
                        sync_en         <= 1'b0;
                        locked          <= 1'b0;
                        nco_clr         <= 1'b1;
                        retries         <= '0;
                        good_cnt_reg    <= '0;
                        bad_cnt_reg     <= '0;
                        acq_win_cnt_reg <= '0;
                    end
                    ACQ: begin
                        good_cnt_reg <= good_next;
                        bad_cnt_reg  <= bad_next;
                        if (win_done) begin
                            if (good_next == LOCK_CNT8) begin
                                state_reg       <= TRACK;
                                gain_sel        <= GAIN_MED;
                                sync_en         <= 1'b1;
                                good_cnt_reg    <= '0;
                                bad_cnt_reg     <= '0;
                                acq_win_cnt_reg <= '0;
                            end else if (acq_win_cnt_reg == ACQ_LAST) begin
                                nco_clr         <= 1'b1;
                                retries         <= sat_inc8(retries);
                                good_cnt_reg    <= '0;
                                bad_cnt_reg     <= '0;
                                acq_win_cnt_reg <= '0;
                            end else begin
                                acq_win_cnt_reg <= acq_win_cnt_reg + ACW'(1);
                            end
                        end
                    end
                    TRACK, LOCKED: begin
                        good_cnt_reg <= good_next;
                        bad_cnt_reg  <= bad_next;
                        if (win_done && (bad_next == UNLOCK_CNT8)) begin
                            state_reg       <= ACQ;
                            gain_sel        <= GAIN_WIDE;
                            sync_en         <= 1'b0;
                            locked          <= 1'b0;
                            lost            <= 1'b1;
                            nco_clr         <= 1'b1;
                            good_cnt_reg    <= '0;
                            bad_cnt_reg     <= '0;
                            acq_win_cnt_reg <= '0;
                        end else if ((state_reg == TRACK) && sync_match) begin
                            state_reg       <= LOCKED;
                            gain_sel        <= GAIN_NARROW;
                            locked          <= 1'b1;
                            good_cnt_reg    <= '0;
                            bad_cnt_reg     <= '0;
                            acq_win_cnt_reg <= '0;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_costas_acq_ctrl.sv
// Scoreboard bench for costas_acq_ctrl: a window/verdict-history reference model predicts the
// registered outputs each cycle; a separate monitor pops and compares one expectation per clock.
module tb_costas_acq_ctrl;

    localparam int W          = 32;
    localparam int SH         = 8;
    localparam int WIN_LOG2   = 3;
    localparam int WIN        = 1 << WIN_LOG2;
    localparam int LOCK_THR   = 1024;
    localparam int LOCK_CNT   = 4;
    localparam int UNLOCK_CNT = 2;
    localparam int ACQ_MAX    = 6;

    logic         clk;
    logic         reset;
    logic         enable;
    logic         PushADC;
    logic [W-1:0] lpf_i;
    logic [W-1:0] lpf_q;
    logic         stopIn;
    logic         sync_match;
    logic [1:0]   gain_sel;
    logic         nco_clr;
    logic         sync_en;
    logic         locked;
    logic         lost;
    logic [1:0]   state;
    logic [7:0]   retries;

    int vectors;
    int miscompares;

    costas_acq_ctrl #(
        .W          (W),
        .SH         (SH),
        .WIN_LOG2   (WIN_LOG2),
        .LOCK_THR   (LOCK_THR),
        .LOCK_CNT   (LOCK_CNT),
        .UNLOCK_CNT (UNLOCK_CNT),
        .ACQ_MAX    (ACQ_MAX)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .PushADC    (PushADC),
        .lpf_i      (lpf_i),
        .lpf_q      (lpf_q),
        .stopIn     (stopIn),
        .sync_match (sync_match),
        .gain_sel   (gain_sel),
        .nco_clr    (nco_clr),
        .sync_en    (sync_en),
        .locked     (locked),
        .lost       (lost),
        .state      (state),
        .retries    (retries)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] gain;
        logic       nco_clr;
        logic       sync_en;
        logic       locked;
        logic       lost;
        logic [1:0] state;
        logic [7:0] retries;
    } out_t;

    out_t exp_q[$];

    // Reference model state: per-window sample list and the verdict history since the last event.
    int     m_state;
    longint m_samples[$];
    bit     m_hist[$];
    int     m_acq_wins;
    int     m_retries;

    function automatic longint mag_of(input logic [31:0] x);
        longint v;
        v = longint'($signed(x));
        if (v < 0) v = -v;
        if (v > 64'sd2147483647) v = 64'sd2147483647;
        return v >>> SH;
    endfunction

    function automatic int trailing(input bit val);
        int n;
        n = 0;
        for (int k = m_hist.size() - 1; k >= 0; k--) begin
            if (m_hist[k] != val) break;
            n++;
        end
        return n;
    endfunction

    function automatic logic [1:0] gain_of(input int s);
        case (s)
            2:       return 2'd1;
            3:       return 2'd0;
            default: return 2'd2;
        endcase
    endfunction

    always @(posedge clk) begin : model
        out_t   e;
        bit     done;
        bit     verdict;
        bit     pulse_clr;
        bit     pulse_lost;
        longint sum;
        done       = 1'b0;
        verdict    = 1'b0;
        pulse_clr  = 1'b0;
        pulse_lost = 1'b0;
        if (!reset) begin
            m_state = 0; m_samples.delete(); m_hist.delete(); m_acq_wins = 0; m_retries = 0;
        end else if (!enable) begin
            m_state = 0; m_samples.delete(); m_hist.delete(); m_acq_wins = 0;
        end else if (m_state == 0) begin
            m_state = 1; pulse_clr = 1'b1; m_retries = 0; m_hist.delete(); m_acq_wins = 0;
        end else begin
            if (PushADC && !stopIn) begin
                m_samples.push_back(mag_of(lpf_i) - mag_of(lpf_q));
                if (m_samples.size() == WIN) begin
                    sum = 0;
                    foreach (m_samples[k]) sum += m_samples[k];
                    verdict = (sum >= LOCK_THR);
                    done = 1'b1;
                    m_samples.delete();
                end
            end
            if (done) m_hist.push_back(verdict);
            if (m_state == 1) begin
                if (done) begin
                    if (trailing(1'b1) == LOCK_CNT) begin
                        m_state = 2; m_hist.delete(); m_acq_wins = 0;
                    end else begin
                        m_acq_wins++;
                        if (m_acq_wins == ACQ_MAX) begin
                            pulse_clr = 1'b1;
                            if (m_retries < 255) m_retries++;
                            m_hist.delete(); m_acq_wins = 0;
                        end
                    end
                end
            end else begin
                if (done && trailing(1'b0) == UNLOCK_CNT) begin
                    m_state = 1; pulse_lost = 1'b1; pulse_clr = 1'b1;
                    m_hist.delete(); m_acq_wins = 0;
                end else if (m_state == 2 && sync_match) begin
                    m_state = 3; m_hist.delete(); m_acq_wins = 0;
                end
            end
        end
        e.gain    = gain_of(m_state);
        e.nco_clr = pulse_clr;
        e.sync_en = (m_state >= 2);
        e.locked  = (m_state == 3);
        e.lost    = pulse_lost;
        e.state   = 2'(m_state);
        e.retries = 8'(m_retries);
        exp_q.push_back(e);
    end

    initial begin : monitor
        out_t got;
        out_t e;
        out_t prev;
        prev = '0;
        forever begin
            @(posedge clk);
            #1;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL scoreboard_empty t=%0t: no expectation for this cycle", $time);
            end else begin
                e   = exp_q.pop_front();
                got = {gain_sel, nco_clr, sync_en, locked, lost, state, retries};
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL outputs t=%0t got gain=%0d clr=%0b sen=%0b lck=%0b lost=%0b st=%0d rt=%0d, want gain=%0d clr=%0b sen=%0b lck=%0b lost=%0b st=%0d rt=%0d",
                             $time, got.gain, got.nco_clr, got.sync_en, got.locked, got.lost, got.state, got.retries,
                             e.gain, e.nco_clr, e.sync_en, e.locked, e.lost, e.state, e.retries);
                end
                if (e.state != prev.state || e.nco_clr || e.lost)
                    $display("txn t=%0t state=%0d gain=%0d nco_clr=%0b lost=%0b locked=%0b retries=%0d",
                             $time, e.state, e.gain, e.nco_clr, e.lost, e.locked, e.retries);
                prev = e;
            end
        end
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic push, input logic [31:0] i, input logic [31:0] q,
                         input logic stop, input logic sm);
        @(negedge clk);
        PushADC    = push;
        lpf_i      = i;
        lpf_q      = q;
        stopIn     = stop;
        sync_match = sm;
    endtask

    task automatic push_n(input int n, input logic [31:0] i, input logic [31:0] q);
        for (int k = 0; k < n; k++) drive(1'b1, i, q, 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] rand_val(input int mode);
        int v;
        case (mode)
            0: v = $urandom_range(30000, 60000);
            1: v = $urandom_range(0, 2000);
            2: v = $urandom_range(0, 60000);
            default: v = ($urandom_range(0, 15) == 0) ? 32'sh8000_0000 : int'($urandom);
        endcase
        if ($urandom_range(0, 1) == 1 && v != 32'sh8000_0000) v = -v;
        return 32'(v);
    endfunction

    localparam logic [31:0] BIG = 32'd40000;
    localparam logic [31:0] MIN_NEG = 32'h8000_0000;

    initial begin : stimulus
        int mode_i;
        int mode_q;
        vectors     = 0;
        miscompares = 0;
        reset      = 1'b0;
        enable     = 1'b0;
        PushADC    = 1'b0;
        lpf_i      = '0;
        lpf_q      = '0;
        stopIn     = 1'b0;
        sync_match = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) drive(1'b0, '0, '0, 1'b0, 1'b0);
        enable = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0);

        // Four good windows reach TRACK, sync_match locks, two bad windows drop back to ACQ.
        push_n(LOCK_CNT * WIN, BIG, '0);
        repeat (3) drive(1'b0, '0, '0, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        repeat (2) drive(1'b0, '0, '0, 1'b0, 1'b0);
        push_n(UNLOCK_CNT * WIN, '0, BIG);
        repeat (3) drive(1'b0, '0, '0, 1'b0, 1'b0);

        // Balanced I/Q never locks: retry counter must climb and saturate at 255.
        push_n(260 * ACQ_MAX * WIN, BIG, BIG);
        repeat (2) drive(1'b0, '0, '0, 1'b0, 1'b0);

        // Backpressure mid-window freezes accumulation, then the window completes.
        push_n(3, BIG, '0);
        for (int k = 0; k < 100; k++) drive(1'b1, '0, BIG, 1'b1, 1'b0);
        push_n(WIN - 3, BIG, '0);

        // Most-negative I must read as a large positive magnitude.
        push_n(WIN, MIN_NEG, '0);

        // Disable on the last sample of a window: return to IDLE takes priority.
        push_n(WIN - 1, BIG, '0);
        @(negedge clk);
        PushADC = 1'b1; lpf_i = BIG; lpf_q = '0; enable = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        enable = 1'b1;
        repeat (2) drive(1'b0, '0, '0, 1'b0, 1'b0);

        // Randomised traffic in regimes that favour locking, losing lock or neither.
        mode_i = 0;
        mode_q = 1;
        for (int c = 0; c < 4000; c++) begin
            if (c % 48 == 0) begin
                mode_i = $urandom_range(0, 3);
                mode_q = $urandom_range(0, 3);
            end
            @(negedge clk);
            PushADC    = ($urandom_range(0, 9) < 7);
            stopIn     = ($urandom_range(0, 9) == 0);
            sync_match = ($urandom_range(0, 19) == 0);
            lpf_i      = rand_val(mode_i);
            lpf_q      = rand_val(mode_q);
            enable     = ($urandom_range(0, 299) != 0);
        end
        enable = 1'b1;

        // Asynchronous reset in the middle of a window takes effect without a clock.
        push_n(3, BIG, '0);
        @(negedge clk);
        PushADC = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if ({state, gain_sel, nco_clr, sync_en, locked, lost, retries} !== {2'd0, 2'd2, 4'b0000, 8'd0}) begin
            miscompares++;
            $display("FAIL async_reset got st=%0d gain=%0d clr=%0b sen=%0b lck=%0b lost=%0b rt=%0d, want st=0 gain=2 all flags 0 rt=0",
                     state, gain_sel, nco_clr, sync_en, locked, lost, retries);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        push_n(LOCK_CNT * WIN, BIG, '0);
        repeat (4) drive(1'b0, '0, '0, 1'b0, 1'b0);

        @(negedge clk);
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
